// File: rtl/delay_event_sched_pkg.sv
// Shared types and widths for the delay event scheduler.
package delay_event_sched_pkg;
   localparam int GRAN_W = 3;
   localparam int REJ_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;
endpackage

// File: rtl/delay_round.sv
// Rounds a delay to a multiple of 2^g ticks, saturating inside W bits.
module delay_round
   import delay_event_sched_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]      d_i,
   input  logic [GRAN_W-1:0] g_i,
   output logic [W-1:0]      d_o
);
   logic [W:0] one;
   logic [W:0] half;
   logic [W:0] sum;
   logic [W:0] rnd;
   logic [W:0] lim;
   logic [W-1:0] ones;

   always_comb begin
      one  = {{W{1'b0}}, 1'b1};
      ones = '1;
      half = (one << g_i) >> 1;
      sum  = {1'b0, d_i} + half;
      rnd  = (sum >> g_i) << g_i;
      lim  = {1'b0, ((ones >> g_i) << g_i)};
      d_o  = (rnd > lim) ? lim[W-1:0] : rnd[W-1:0];
   end
endmodule

// File: rtl/delay_event_sched.sv
// Inertial delay scheduler: forwards in to out after a per-edge delay.
module delay_event_sched
   import delay_event_sched_pkg::*;
#(
   parameter int   W         = 16,
   parameter logic RESET_OUT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [W-1:0]      cfg_rise,
   input  logic [W-1:0]      cfg_fall,
   input  logic [GRAN_W-1:0] cfg_gran,
   output logic              out,
   output logic              pending,
   output logic [REJ_W-1:0]  reject_cnt
);
   state_e              state_q, state_d;
   logic                samp_q, samp_d;
   logic                out_q, out_d;
   logic                val_q, val_d;
   logic [W-1:0]        cnt_q, cnt_d;
   logic [REJ_W-1:0]    rej_q, rej_d;
   logic [W-1:0]        rise_q, rise_d;
   logic [W-1:0]        fall_q, fall_d;
   logic [GRAN_W-1:0]   gran_q, gran_d;
   logic [W-1:0]        rise_eff, fall_eff;
   logic [W-1:0]        load;
   logic                chg;

   delay_round #(.W(W)) u_rise (
      .d_i (rise_q),
      .g_i (gran_q),
      .d_o (rise_eff)
   );

   delay_round #(.W(W)) u_fall (
      .d_i (fall_q),
      .g_i (gran_q),
      .d_o (fall_eff)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         samp_q  <= RESET_OUT;
         out_q   <= RESET_OUT;
         val_q   <= RESET_OUT;
         cnt_q   <= '0;
         rej_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         gran_q  <= '0;
      end else begin
         state_q <= state_d;
         samp_q  <= samp_d;
         out_q   <= out_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         rej_q   <= rej_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         gran_q  <= gran_d;
      end
   end

   // A zero effective delay still takes one edge to reach out.
   always_comb begin
      load = in ? rise_eff : fall_eff;
      if (load == '0) begin
         load = {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      chg     = (samp_q != in);
      state_d = state_q;
      samp_d  = in;
      out_d   = out_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      rej_d   = rej_q;
      rise_d  = rise_q;
      fall_d  = fall_q;
      gran_d  = gran_q;
      if (cfg_valid && (state_q == IDLE)) begin
         rise_d = cfg_rise;
         fall_d = cfg_fall;
         gran_d = cfg_gran;
      end
      unique case (state_q)
         IDLE: begin
            if (chg && (in != out_q)) begin
               state_d = PEND;
               val_d   = in;
               cnt_d   = load;
            end
         end
         PEND: begin
            if (cnt_q == {{(W-1){1'b0}}, 1'b1}) begin
               out_d   = val_q;
               state_d = IDLE;
               if (chg && (in != val_q)) begin
                  state_d = PEND;
                  val_d   = in;
                  cnt_d   = load;
               end
            end else if (chg) begin
               state_d = IDLE;
               if (rej_q != '1) begin
                  rej_d = rej_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pending    = (state_q == PEND);
      cfg_ready  = (state_q == IDLE);
      out        = out_q;
      reject_cnt = rej_q;
   end
endmodule

// File: tb/tb_delay_event_sched.sv
// Directed bench for delay_event_sched with an event-time reference model.
module tb_delay_event_sched;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [W-1:0]  cfg_rise = '0;
   logic [W-1:0]  cfg_fall = '0;
   logic [2:0]    cfg_gran = '0;
   logic          out;
   logic          pending;
   logic [7:0]    reject_cnt;

   delay_event_sched #(.W(W), .RESET_OUT(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_rise   (cfg_rise),
      .cfg_fall   (cfg_fall),
      .cfg_gran   (cfg_gran),
      .out        (out),
      .pending    (pending),
      .reject_cnt (reject_cnt)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int ec = 0;
   int toggles = 0;
   logic prev_out = 1'b0;

   // model: event time bookkeeping in absolute edge numbers
   logic m_out, m_samp, m_pend, m_val;
   int   m_exp, m_rej, m_rise, m_fall, m_g;

   function automatic int deff(int d, int g);
      int r, mx;
      r  = ((d + ((1 << g) >> 1)) >> g) << g;
      mx = (((1 << W) - 1) >> g) << g;
      return (r > mx) ? mx : r;
   endfunction

   task automatic chk(string name, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
      end
   endtask

   task automatic m_reset();
      m_out = 1'b0; m_samp = 1'b0; m_pend = 1'b0; m_val = 1'b0;
      m_exp = 0; m_rej = 0; m_rise = 0; m_fall = 0; m_g = 0;
   endtask

   task automatic m_sched(logic v);
      int d;
      d = v ? deff(m_rise, m_g) : deff(m_fall, m_g);
      if (d < 1) d = 1;
      m_pend = 1'b1;
      m_val  = v;
      m_exp  = ec + d;
   endtask

   task automatic m_step();
      logic chg, acc;
      if (rst) begin
         m_reset();
         return;
      end
      chg = (in != m_samp);
      acc = cfg_valid && !m_pend;
      if (m_pend && ec == m_exp) begin
         m_out  = m_val;
         m_pend = 1'b0;
         if (chg && in != m_out) m_sched(in);
      end else if (m_pend && chg) begin
         m_pend = 1'b0;
         if (m_rej < 255) m_rej++;
      end else if (!m_pend && chg && in != m_out) begin
         m_sched(in);
      end
      if (acc) begin
         m_rise = int'(cfg_rise);
         m_fall = int'(cfg_fall);
         m_g    = int'(cfg_gran);
      end
      m_samp = in;
   endtask

   task automatic compare();
      chk("out", int'(out), int'(m_out));
      chk("pending", int'(pending), int'(m_pend));
      chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
      chk("reject_cnt", int'(reject_cnt), m_rej);
   endtask

   task automatic tick();
      @(posedge clk);
      ec++;
      m_step();
      #1;
      if (out !== prev_out) toggles++;
      prev_out = out;
      compare();
   endtask

   task automatic cfg(int r, int f, int g);
      cfg_rise  = W'(r);
      cfg_fall  = W'(f);
      cfg_gran  = 3'(g);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic drive_lat(logic v, int bound, output int lat);
      in = v;
      tick();
      lat = 0;
      while (out !== v && lat < bound) begin
         tick();
         lat++;
      end
      if (out !== v) chk("timeout", lat, -1);
   endtask

   int lat;

   initial begin
      m_reset();
      #1;
      chk("rst_out", int'(out), 0);
      chk("rst_pending", int'(pending), 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("idle_ready", int'(cfg_ready), 1);
      chk("idle_rej", int'(reject_cnt), 0);

      chk("deff_5_g2", deff(5, 2), 4);
      chk("deff_6_g2", deff(6, 2), 8);
      chk("deff_max_g2", deff(65535, 2), 65532);

      cfg(5, 3, 0);
      repeat (3) tick();
      drive_lat(1'b1, 20, lat);
      chk("rise5_lat", lat, 5);
      repeat (2) tick();
      drive_lat(1'b0, 20, lat);
      chk("fall3_lat", lat, 3);

      in = 1'b1;
      tick();
      tick();
      in = 1'b0;
      tick();
      chk("rej_pending", int'(pending), 0);
      chk("rej_cnt", int'(reject_cnt), 1);
      chk("rej_out", int'(out), 0);
      repeat (8) tick();

      cfg(5, 3, 2);
      drive_lat(1'b1, 20, lat);
      chk("g2_rise5", lat, 4);
      drive_lat(1'b0, 20, lat);
      chk("g2_fall3", lat, 4);
      cfg(6, 3, 2);
      drive_lat(1'b1, 20, lat);
      chk("g2_rise6", lat, 8);
      drive_lat(1'b0, 20, lat);
      cfg(65535, 3, 2);
      drive_lat(1'b1, 70000, lat);
      chk("g2_risemax", lat, 65532);
      drive_lat(1'b0, 20, lat);

      cfg(0, 0, 0);
      drive_lat(1'b1, 10, lat);
      chk("rise0_lat", lat, 1);
      drive_lat(1'b0, 10, lat);
      toggles = 0;
      for (int i = 0; i < 6; i++) begin
         in = ~in;
         tick();
      end
      tick();
      tick();
      chk("b2b_toggles", toggles, 6);
      chk("b2b_final", int'(out), int'(in));

      cfg(5, 3, 0);
      in = 1'b1;
      tick();
      cfg_valid = 1'b1;
      cfg_rise  = W'(2);
      tick();
      chk("held_ready", int'(cfg_ready), 0);
      lat = 1;
      while (out !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("held_old_delay", lat, 5);
      tick();
      cfg_valid = 1'b0;
      drive_lat(1'b0, 20, lat);
      chk("held_fall", lat, 3);
      drive_lat(1'b1, 20, lat);
      chk("held_new_rise", lat, 2);

      cfg(5, 3, 0);
      drive_lat(1'b0, 20, lat);
      in = 1'b1;
      tick();
      tick();
      tick();
      in  = 1'b0;
      rst = 1'b1;
      #1;
      m_reset();
      chk("mid_rst_out", int'(out), 0);
      chk("mid_rst_pend", int'(pending), 0);
      chk("mid_rst_rej", int'(reject_cnt), 0);
      prev_out = out;
      tick();
      tick();
      rst = 1'b0;
      toggles = 0;
      repeat (10) tick();
      chk("post_rst_quiet", toggles, 0);
      drive_lat(1'b1, 10, lat);
      chk("post_rst_rise", lat, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
